// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// Optional feature macro: REGFILE_SCOREBOARD_EN (pending-bit scoreboard).
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp: read ports, write port, clears and handshake.
// REGFILE_SCOREBOARD_EN adds the reservation inputs and per-port pending outputs.
interface reg_file_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = clog2(NUM_REGS)
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ready;
    logic                     clr_one;
    logic                     clr_all;
    logic                     busy;
`ifdef REGFILE_SCOREBOARD_EN
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_RD-1:0]        rd_pend;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_one, clr_all, rsv_en, rsv_addr,
        input  rd_data, wr_ready, busy, rd_pend
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_one, clr_all, rsv_en, rsv_addr,
        output rd_data, wr_ready, busy, rd_pend
    );
`else
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_one, clr_all,
        input  rd_data, wr_ready, busy
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_one, clr_all,
        output rd_data, wr_ready, busy
    );
`endif
endinterface

// File: rtl/regfile_clr_seq.sv
// Clear-all sequencer: walks sweep_idx over every register once, one per cycle,
// holding busy high and wr_ready low for exactly NUM_REGS cycles.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_all,
    output logic              busy,
    output logic              wr_ready,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Terminal compare on the last index stops the counter before it can wrap.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy     = 1'b0;
        wr_ready = 1'b1;
        sweep_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_all) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                busy     = 1'b1;
                wr_ready = 1'b0;
                sweep_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign sweep_idx = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered, write-forwarded reads, single clear
// and sequenced clear-all. REGFILE_SCOREBOARD_EN adds per-register pending bits.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_mp_if.slave   bus
);
    localparam int ADDR_W = clog2(NUM_REGS);

    logic              wr_ready;
    logic              busy;
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [ADDR_W-1:0] rd_addr_w [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_accept;
    logic              clr_accept;

    regfile_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_all   (bus.clr_all),
        .busy      (busy),
        .wr_ready  (wr_ready),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_addr
            assign rd_addr_w[gi] = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // wr_ready is low for the whole sweep, so sweep and port updates never collide.
    assign clr_accept = wr_ready & bus.clr_one;
    assign wr_accept  = wr_ready & bus.wr_en & ~bus.clr_one;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (sweep_en) begin
            regs_d[sweep_idx] = '0;
        end else if (clr_accept) begin
            regs_d[bus.wr_addr] = '0;
        end else if (wr_accept) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Reading the next-state array gives same-cycle write/clear forwarding for free.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*DATA_W +: DATA_W] = regs_d[rd_addr_w[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.wr_ready = wr_ready;
    assign bus.busy     = busy;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_RD-1:0]   rd_pend_q, rd_pend_d;

    // Set first, then clear, so a clear of the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (bus.rsv_en) begin
            pend_d[bus.rsv_addr] = 1'b1;
        end
        if (sweep_en) begin
            pend_d[sweep_idx] = 1'b0;
        end else if (clr_accept || wr_accept) begin
            pend_d[bus.wr_addr] = 1'b0;
        end
    end

    always_comb begin
        rd_pend_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_pend_d[k] = pend_d[rd_addr_w[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            pend_q    <= pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.rd_pend = rd_pend_q;
`endif

endmodule
